// File: rtl/cpu65el02_pkg.sv
// Shared types and constants for the 65EL02 sequential divider.
// Signed operation is compiled in with CPU65EL02_DIV_SIGNED_EN.
package cpu65el02_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_ITER  = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } div_state_e;

    localparam logic [5:0]  ITER_CNT_16 = 6'd32;
    localparam logic [5:0]  ITER_CNT_8  = 6'd16;
    localparam logic [15:0] DIVZERO_QUO = 16'hFFFF;

    // Widen an 8-bit value to 16 bits, sign- or zero-extending.
    function automatic logic [15:0] ext8(input logic [7:0] v, input logic sx);
        return {{8{sx & v[7]}}, v};
    endfunction

endpackage

// File: rtl/cpu65el02_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module cpu65el02_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, div_i};
    // rem_i < div_i keeps shifted below 2*div_i, so the top bit of diff is the borrow.
    assign q_o     = ~diff[WIDTH];
    assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/cpu65el02_seq_div.sv
// Sequential 32/16 (or 16/8) divider for the 65EL02 DIV instructions.
// Signed operands are supported only when CPU65EL02_DIV_SIGNED_EN is defined.
module cpu65el02_seq_div
    import cpu65el02_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] B,
    input  logic             Size,
    input  logic             Signed,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             OutFlagV,
    output logic             DivZero
);
    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [15:0] a_q, d_q, b_q;
    logic        size_q;
    logic [31:0] quo_q, quo_d;
    logic [15:0] rem_q, rem_d, div_q, div_d;
    logic        qneg_q, qneg_d, zdiv_q, zdiv_d;
    logic [15:0] q_out_q, q_out_d, r_out_q, r_out_d;
    logic        v_q, v_d, dz_q, dz_d;

    logic        sgn;
    logic [31:0] dvd_ext, dvd_mag;
    logic [15:0] dvs_ext, dvs_mag;
    logic        dvd_neg, dvs_neg;
    logic [31:0] qmag, qlim;
    logic [15:0] qres, rres;
    logic [15:0] step_rem;
    logic        step_q;

    assign dvd_ext = size_q ? {{16{sgn & d_q[7]}}, d_q[7:0], a_q[7:0]} : {d_q, a_q};
    assign dvs_ext = size_q ? ext8(b_q[7:0], sgn) : b_q;
    assign qmag    = size_q ? {16'h0, quo_q[15:0]} : quo_q;

`ifdef CPU65EL02_DIV_SIGNED_EN
    logic sgn_q, rneg_q;

    assign sgn     = sgn_q;
    assign dvd_neg = sgn & dvd_ext[31];
    assign dvs_neg = sgn & dvs_ext[15];
    assign dvd_mag = dvd_neg ? (~dvd_ext) + 32'd1 : dvd_ext;
    assign dvs_mag = dvs_neg ? (~dvs_ext) + 16'd1 : dvs_ext;
    assign qres    = qneg_q ? (~qmag[15:0]) + 16'd1 : qmag[15:0];
    assign rres    = rneg_q ? (~rem_q) + 16'd1 : rem_q;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            sgn_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && Start) sgn_q <= Signed;
            if (state_q == ST_SETUP) rneg_q <= dvd_neg;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = Signed;
    assign sgn     = 1'b0;
    assign dvd_neg = 1'b0;
    assign dvs_neg = 1'b0;
    assign dvd_mag = dvd_ext;
    assign dvs_mag = dvs_ext;
    assign qres    = qmag[15:0];
    assign rres    = rem_q;
`endif

    // Largest quotient magnitude that still fits the destination range.
    always_comb begin
        if (size_q) qlim = qneg_q ? 32'd128 : (sgn ? 32'd127 : 32'd255);
        else        qlim = qneg_q ? 32'd32768 : (sgn ? 32'd32767 : 32'd65535);
    end

    cpu65el02_div_step #(.WIDTH(16)) u_step (
        .rem_i (rem_q),
        .bit_i (quo_q[31]),
        .div_i (div_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        div_d   = div_q;
        qneg_d  = qneg_q;
        zdiv_d  = zdiv_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        v_d     = v_q;
        dz_d    = dz_q;
        unique case (state_q)
            ST_IDLE: begin
                if (Start) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                quo_d  = size_q ? {dvd_mag[15:0], 16'h0} : dvd_mag;
                rem_d  = '0;
                div_d  = dvs_mag;
                qneg_d = dvd_neg ^ dvs_neg;
                zdiv_d = (dvs_ext == '0);
                // A zero divisor skips the loop; FIXUP still costs one cycle so Done lands at k+2.
                if (dvs_ext == '0) begin
                    cnt_d   = '0;
                    state_d = ST_FIXUP;
                end else begin
                    cnt_d   = size_q ? ITER_CNT_8 : ITER_CNT_16;
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
                quo_d = {quo_q[30:0], step_q};
                rem_d = step_rem;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) state_d = ST_FIXUP;
            end
            ST_FIXUP: begin
                if (zdiv_q) begin
                    q_out_d = DIVZERO_QUO;
                    r_out_d = a_q;
                    v_d     = 1'b1;
                    dz_d    = 1'b1;
                end else begin
                    q_out_d = size_q ? ext8(qres[7:0], sgn) : qres;
                    r_out_d = size_q ? ext8(rres[7:0], sgn) : rres;
                    v_d     = (qmag > qlim);
                    dz_d    = 1'b0;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            d_q     <= '0;
            b_q     <= '0;
            size_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            qneg_q  <= 1'b0;
            zdiv_q  <= 1'b0;
            q_out_q <= '0;
            r_out_q <= '0;
            v_q     <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            qneg_q  <= qneg_d;
            zdiv_q  <= zdiv_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            v_q     <= v_d;
            dz_q    <= dz_d;
            if (state_q == ST_IDLE && Start) begin
                a_q    <= A;
                d_q    <= D;
                b_q    <= B;
                size_q <= Size;
            end
        end
    end

    assign Busy      = (state_q != ST_IDLE);
    assign Done      = (state_q == ST_DONE);
    assign Quotient  = q_out_q;
    assign Remainder = r_out_q;
    assign OutFlagV  = v_q;
    assign DivZero   = dz_q;
endmodule

// File: tb/tb_cpu65el02_seq_div.sv
// Scoreboard bench for cpu65el02_seq_div: directed corner cases plus random operands.
module tb_cpu65el02_seq_div;
    logic        Clk = 1'b0;
    logic        nReset = 1'b1;
    logic        Start = 1'b0;
    logic [15:0] A = '0, D = '0, B = '0;
    logic        Size = 1'b0, Signed = 1'b0;
    logic        Busy, Done, OutFlagV, DivZero;
    logic [15:0] Quotient, Remainder;

    cpu65el02_seq_div #(.WIDTH(16)) dut (
        .Clk(Clk), .nReset(nReset), .Start(Start), .A(A), .D(D), .B(B),
        .Size(Size), .Signed(Signed), .Busy(Busy), .Done(Done),
        .Quotient(Quotient), .Remainder(Remainder), .OutFlagV(OutFlagV), .DivZero(DivZero)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        v;
        logic        dz;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          nvec = 0, nerr = 0, cyc = 0;
    bit          have_last = 0;
    logic [33:0] last_out;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer division on the operands as the ISA defines them.
    function automatic exp_t model(input logic [15:0] a, d, b, input logic sz, sg, input int k);
        exp_t        e;
        longint      dvd, dvs, q, r, lo, hi;
        bit          s;
        logic [15:0] w16;
        logic [7:0]  b8;
        logic [31:0] w32;
`ifdef CPU65EL02_DIV_SIGNED_EN
        s = sg;
`else
        s = 1'b0;
        if (sg) s = 1'b0;
`endif
        if (sz) begin
            w16 = {d[7:0], a[7:0]};
            b8  = b[7:0];
            dvd = s ? longint'($signed(w16)) : longint'(w16);
            dvs = s ? longint'($signed(b8)) : longint'(b8);
            lo  = s ? -128 : 0;
            hi  = s ? 127 : 255;
        end else begin
            w32 = {d, a};
            dvd = s ? longint'($signed(w32)) : longint'(w32);
            dvs = s ? longint'($signed(b)) : longint'(b);
            lo  = s ? -32768 : 0;
            hi  = s ? 32767 : 65535;
        end
        if (dvs == 0) begin
            e.q = 16'hFFFF; e.r = a; e.v = 1'b1; e.dz = 1'b1; e.due = k + 2;
            return e;
        end
        q = dvd / dvs;
        r = dvd % dvs;
        e.v  = (q < lo) || (q > hi);
        e.dz = 1'b0;
        if (sz) begin
            e.q = s ? {{8{q[7]}}, q[7:0]} : {8'h00, q[7:0]};
            e.r = s ? {{8{r[7]}}, r[7:0]} : {8'h00, r[7:0]};
            e.due = k + 18;
        end else begin
            e.q = q[15:0];
            e.r = r[15:0];
            e.due = k + 34;
        end
        return e;
    endfunction

    // Monitor: pops on every Done, and checks results hold while idle.
    initial forever begin
        @(negedge Clk);
        if (Done) begin
            if (exp_q.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL unexpected_done: got Done=1 expected no pending op (t=%0t)", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("quotient", Quotient, e.q);
                chk("remainder", Remainder, e.r);
                chk("flag_v", OutFlagV, e.v);
                chk("divzero", DivZero, e.dz);
                chk("latency", cyc, e.due);
                last_out  = {Quotient, Remainder, OutFlagV, DivZero};
                have_last = 1;
            end
        end else if (!Busy && have_last && nReset) begin
            chk("hold_outputs", {Quotient, Remainder, OutFlagV, DivZero}, last_out);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (Busy) begin
            nvec++; nerr++;
            $display("FAIL idle_timeout: got Busy=1 expected 0 within 200 cycles");
        end
    endtask

    // Called at a negedge; leaves the caller at the negedge after the accepting edge.
    task automatic issue(input logic [15:0] a, d, b, input logic sz, sg);
        wait_idle();
        A = a; D = d; B = b; Size = sz; Signed = sg; Start = 1'b1;
        exp_q.push_back(model(a, d, b, sz, sg, cyc + 1));
        @(negedge Clk);
        Start = 1'b0;
        A = 16'($urandom); D = 16'($urandom); B = 16'($urandom);
        Size = 1'($urandom); Signed = 1'($urandom);
    endtask

    task automatic run(input logic [15:0] a, d, b, input logic sz, sg);
        issue(a, d, b, sz, sg);
        wait_idle();
    endtask

    initial begin
        int n;
        logic [15:0] ra, rd, rb;
        #1 nReset = 1'b0;
        @(negedge Clk);
        chk("reset_outputs", {Busy, Done, Quotient, Remainder, OutFlagV, DivZero}, 64'h0);
        nReset = 1'b1;

        run(16'h0000, 16'h0001, 16'h0010, 1'b0, 1'b0);
        run(16'h00F9, 16'h00FF, 16'h0002, 1'b1, 1'b1);
        run(16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0);
        run(16'h0000, 16'h0010, 16'h0001, 1'b0, 1'b0);
        run(16'h8000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        run(16'h0080, 16'h0000, 16'hFF00, 1'b1, 1'b1);

        // Start while busy, then Start coinciding with Done: both ignored.
        issue(16'h4321, 16'h0002, 16'h0077, 1'b0, 1'b0);
        repeat (4) @(negedge Clk);
        A = 16'h1111; D = 16'h0000; B = 16'h0003; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        n = 0;
        while (!Done && n < 100) begin @(negedge Clk); n++; end
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("start_on_done_ignored", Busy, 1'b0);

        // Reset in the middle of an operation.
        issue(16'hBEEF, 16'h0123, 16'h0456, 1'b0, 1'b0);
        repeat (9) @(negedge Clk);
        @(posedge Clk);
        #2 nReset = 1'b0;
        have_last = 0;
        exp_q.delete();
        #1 chk("midop_reset", {Busy, Done, Quotient, Remainder, OutFlagV, DivZero}, 64'h0);
        repeat (3) @(negedge Clk);
        nReset = 1'b1;
        run(16'h0064, 16'h0000, 16'h0007, 1'b1, 1'b0);

        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom); rd = 16'($urandom); rb = 16'($urandom);
            case ($urandom_range(0, 9))
                0:       rb = 16'h0000;
                1:       rb = 16'h0100;
                2, 3:    rb = 16'($urandom_range(1, 15));
                4:       rd = 16'($urandom_range(0, 3));
                default: ;
            endcase
            issue(ra, rd, rb, 1'($urandom), 1'($urandom));
            n = $urandom_range(0, 20);
            repeat (n) begin
                if (Busy) begin
                    A = 16'($urandom); B = 16'($urandom); Start = 1'b1;
                    @(negedge Clk);
                    Start = 1'b0;
                end else begin
                    @(negedge Clk);
                end
            end
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge Clk);
        end

        repeat (3) @(negedge Clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
